osc_bank: RTL

OSC_BANK -- requirements
Module: osc_bank

---
 rtl/osc_pkg.sv | 13 +
 rtl/osc_sine_lut.sv | 27 ++
 rtl/osc_bank.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/osc_pkg.sv
// rtl/osc_pkg.sv - shared enums and default constants for the oscillator bank
package osc_pkg;

    typedef enum logic [1:0] {SAW, SQUARE, TRI, SINE} wave_e;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int DEF_NUM_VOICES = 4;
    localparam int DEF_SAMPLE_W   = 16;
    localparam int DEF_PHASE_W    = 24;
    localparam int DEF_CLK_DIV    = 1000;
    localparam int DEF_LUT_AW     = 8;

endpackage

// File: rtl/osc_sine_lut.sv
// rtl/osc_sine_lut.sv - combinational quarter-wave sine magnitude table
module osc_sine_lut
    import osc_pkg::*;
#(
    parameter int LUT_AW   = DEF_LUT_AW,
    parameter int SAMPLE_W = DEF_SAMPLE_W
) (
    input  logic [LUT_AW-1:0]   addr,
    output logic [SAMPLE_W-1:0] mag
);

    localparam int  DEPTH   = 1 << LUT_AW;
    localparam real MAX_R   = real'((1 << (SAMPLE_W - 1)) - 1);
    localparam real HALF_PI = 1.5707963267948966;

    logic [SAMPLE_W-1:0] rom [DEPTH];

    // First entry is 0, last entry is exactly +max so mirrored halves meet cleanly.
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam real ANG = HALF_PI * real'(i) / real'(DEPTH - 1);
        localparam int  VAL = int'($sin(ANG) * MAX_R);
        assign rom[i] = SAMPLE_W'(VAL);
    end

    assign mag = rom[addr];

endmodule

// File: rtl/osc_bank.sv
// rtl/osc_bank.sv - time-multiplexed oscillator bank mixer; OSC_BANK_SINE_EN enables the sine LUT
module osc_bank
    import osc_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int SAMPLE_W   = DEF_SAMPLE_W,
    parameter int PHASE_W    = DEF_PHASE_W,
    parameter int CLK_DIV    = DEF_CLK_DIV
) (
    input  logic                          i_clk48,
    input  logic                          i_rst48,
    input  logic                          i_pause,
    input  logic                          i_cfg_we,
    input  logic [$clog2(NUM_VOICES)-1:0] i_cfg_voice,
    input  logic [PHASE_W-1:0]            i_cfg_inc,
    input  logic [1:0]                    i_cfg_wave,
    input  logic                          i_cfg_en,
    output logic [SAMPLE_W-1:0]           o_sample,
    output logic                          o_valid,
    output logic                          o_busy
);

    localparam int VW    = $clog2(NUM_VOICES);
    localparam int ACC_W = SAMPLE_W + VW;
    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0]      cnt;
    logic                  tick;
    state_e                state, state_nx;
    logic [VW-1:0]         vidx;
    logic                  last;
    logic [ACC_W-1:0]      acc, acc_sum;

    logic [PHASE_W-1:0]    phase [NUM_VOICES];
    logic [PHASE_W-1:0]    inc   [NUM_VOICES];
    logic [1:0]            wave  [NUM_VOICES];
    logic [NUM_VOICES-1:0] en;

    logic [PHASE_W-1:0]    cur_phase, cur_inc, phase_sum;
    wave_e                 cur_wave;
    logic                  cur_en;
    logic [SAMPLE_W-1:0]   p, saw_v, sq_v, tri_s, tri_v, sine_v, wave_v, contrib;
    logic                  m;

    assign tick   = (cnt == CNT_W'(CLK_DIV - 1));
    assign last   = (vidx == VW'(NUM_VOICES - 1));
    assign o_busy = (state != IDLE);

    assign cur_phase = phase[vidx];
    assign cur_inc   = inc[vidx];
    assign cur_wave  = wave_e'(wave[vidx]);
    assign cur_en    = en[vidx];
    assign phase_sum = cur_phase + cur_inc;

    assign p     = cur_phase[PHASE_W-1 -: SAMPLE_W];
    assign m     = p[SAMPLE_W-1];
    assign saw_v = {~m, p[SAMPLE_W-2:0]};
    assign sq_v  = m ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
    assign tri_s = (m ? ~p : p) << 1;
    assign tri_v = {~tri_s[SAMPLE_W-1], tri_s[SAMPLE_W-2:0]};

`ifdef OSC_BANK_SINE_EN
    localparam int LUT_AW = DEF_LUT_AW;
    logic [LUT_AW-1:0]   lut_idx;
    logic [SAMPLE_W-1:0] lut_mag;

    // Second quadrant of each half-cycle reads the table backwards.
    assign lut_idx = cur_phase[PHASE_W-2] ? ~cur_phase[PHASE_W-3 -: LUT_AW]
                                          :  cur_phase[PHASE_W-3 -: LUT_AW];

    osc_sine_lut #(
        .LUT_AW   (LUT_AW),
        .SAMPLE_W (SAMPLE_W)
    ) u_sine_lut (
        .addr (lut_idx),
        .mag  (lut_mag)
    );

    assign sine_v = m ? -lut_mag : lut_mag;
`else
    assign sine_v = tri_v;
`endif

    always_comb begin
        wave_v = saw_v;
        case (cur_wave)
            SAW:     wave_v = saw_v;
            SQUARE:  wave_v = sq_v;
            TRI:     wave_v = tri_v;
            SINE:    wave_v = sine_v;
            default: wave_v = saw_v;
        endcase
    end

    assign contrib = cur_en ? wave_v : '0;
    assign acc_sum = acc + {{VW{contrib[SAMPLE_W-1]}}, contrib};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (tick) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk48) begin
        if (i_rst48) begin
            cnt      <= '0;
            state    <= IDLE;
            vidx     <= '0;
            acc      <= '0;
            o_sample <= '0;
            o_valid  <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= tick ? '0 : cnt + CNT_W'(1);
            o_valid <= 1'b0;
            if (tick) begin
                acc  <= '0;
                vidx <= '0;
            end else if (state == RUN) begin
                acc  <= acc_sum;
                vidx <= vidx + VW'(1);
                // Top SAMPLE_W bits of the final sum are the arithmetic-shifted average.
                if (last) begin
                    o_sample <= acc_sum[ACC_W-1 -: SAMPLE_W];
                    o_valid  <= 1'b1;
                end
            end
        end
    end

    // A config write lands after the RUN update in this block, so a disable still zeroes phase.
    always_ff @(posedge i_clk48) begin
        if (i_rst48) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase[v] <= '0;
                inc[v]   <= '0;
                wave[v]  <= '0;
            end
            en <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (state == RUN && vidx == VW'(v) && en[v] && !i_pause)
                    phase[v] <= phase_sum;
                if (i_cfg_we && i_cfg_voice == VW'(v)) begin
                    inc[v]  <= i_cfg_inc;
                    wave[v] <= i_cfg_wave;
                    en[v]   <= i_cfg_en;
                    if (!i_cfg_en)
                        phase[v] <= '0;
                end
            end
        end
    end

endmodule
